// File: rtl/ws2812_tx.sv
// ---------------------------------------------------------------------------
// ws2812_tx
//
// Serial line encoder for a WS2812 LED chain. On a trigger it waits for the
// frame-buffer read port to settle, then takes one byte at a time and sends
// each one MSB-first as pulse-width coded bits. A `next` pulse tells the
// address sequencer that the byte has been taken. When the sequencer reports
// `done` at a load point, the line is held low for the latch period and the
// encoder returns to idle.
//
// Parameters (all in clk_i cycles):
//   T0H     high time of a 0 bit
//   T1H     high time of a 1 bit
//   TBIT    full bit period
//   TRESET  low latch time at end of frame
//   RD_LAT  cycles from trigger/next until data/done are valid
//   Legal: 0 < T0H < T1H < TBIT, TRESET >= 1, RD_LAT >= 1
//
// Ports:
//   clk_i      in   1  single clock, rising edge
//   reset_i    in   1  synchronous, active-high reset
//   trigger_i  in   1  frame start pulse, sampled only in IDLE
//   data_i     in   8  frame-buffer byte at the sequencer's current address
//   done_i     in   1  sequencer has no further byte
//   next_o     out  1  one-cycle pulse: current byte consumed
//   dout_o     out  1  WS2812 serial data line
//   busy_o     out  1  frame in progress (WAIT, BIT or LATCH)
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | line low, waiting for trigger
// WAIT  | read-port latency after trigger; ends in the first load point
// BIT   | shifting out sr_q[7]; last cycle of bit 0 is a load point
// LATCH | line low for TRESET cycles, then back to IDLE
// ---------------------------------------------------------------------------
module ws2812_tx #(
  parameter int T0H    = 17,
  parameter int T1H    = 34,
  parameter int TBIT   = 60,
  parameter int TRESET = 2880,
  parameter int RD_LAT = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       trigger_i,
  input  logic [7:0] data_i,
  input  logic       done_i,
  output logic       next_o,
  output logic       dout_o,
  output logic       busy_o
);

  // One down-counter serves all three timed states, so it is sized for the
  // longest of them.
  localparam int CNT_MAX_A = (TRESET - 1 > TBIT - 1) ? (TRESET - 1) : (TBIT - 1);
  localparam int CNT_MAX   = (CNT_MAX_A > RD_LAT) ? CNT_MAX_A : RD_LAT;
  localparam int CW        = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] WAIT_INIT  = CW'(RD_LAT);
  localparam logic [CW-1:0] BIT_INIT   = CW'(TBIT - 1);
  localparam logic [CW-1:0] LATCH_INIT = CW'(TRESET - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // The bit counter runs down from TBIT-1, so the elapsed time in the bit is
  // TBIT-1-cnt. "elapsed < TxH" becomes "cnt >= TBIT-TxH".
  localparam logic [CW-1:0] HI1_FLOOR = CW'(TBIT - T1H);
  localparam logic [CW-1:0] HI0_FLOOR = CW'(TBIT - T0H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BIT   = 2'd2,
    S_LATCH = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    sr_q, sr_d;
  logic          next_q, next_d;
  logic          dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          load;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      sr_q      <= '0;
      next_q    <= 1'b0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sr_q      <= sr_d;
      next_q    <= next_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    next_d    = 1'b0;
    busy_d    = busy_q;
    load      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (trigger_i) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
          busy_d  = 1'b1;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          load = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_BIT: begin
        if (cnt_q == '0) begin
          if (bit_idx_q != 3'd0) begin
            sr_d      = {sr_q[6:0], 1'b0};
            bit_idx_d = bit_idx_q - 3'd1;
            cnt_d     = BIT_INIT;
          end else begin
            load = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_LATCH: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Load point: the byte (or the end marker) is taken here, and the next
    // byte's first bit starts on the following cycle with no gap.
    if (load) begin
      if (done_i) begin
        state_d = S_LATCH;
        cnt_d   = LATCH_INIT;
      end else begin
        state_d   = S_BIT;
        sr_d      = data_i;
        bit_idx_d = 3'd7;
        cnt_d     = BIT_INIT;
        next_d    = 1'b1;
      end
    end

    // dout is registered, so it is derived from the values the counter and
    // shift register will hold in the cycle it is driven.
    dout_d = (state_d == S_BIT) &&
             (cnt_d >= (sr_d[7] ? HI1_FLOOR : HI0_FLOOR));
  end

  assign next_o = next_q;
  assign dout_o = dout_q;
  assign busy_o = busy_q;

endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Serial line encoder for the WS2812 LED chain. It consumes the byte stream produced by the `send` address sequencer. On `trigger` it fetches bytes from the frame buffer read port, serialises each MSB-first as WS2812 pulse-width bits, and pulses `next` to advance the sequencer. When the sequencer reports `done`, it ends the frame with a low latch period. It sits between the frame-buffer read port and the LED output pin, and is the consumer end of the `send` handshake (`trigger`/`next`/`done`).

## Interface

Parameters (all in `clk` cycles; defaults are for 48 MHz):
- `T0H`, default 17: high time of a 0 bit.
- `T1H`, default 34: high time of a 1 bit.
- `TBIT`, default 60: full bit period.
- `TRESET`, default 2880: low latch time at end of frame.
- `RD_LAT`, default 2: cycles from `trigger`/`next` until `data` and `done` are valid.
- Legal range: 0 < `T0H` < `T1H` < `TBIT`; `TRESET` ≥ 1; `RD_LAT` ≥ 1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `trigger`  in  1: frame start pulse, shared with `send`. Sampled only in IDLE.
- `data`  in  8: frame buffer byte at the sequencer's current `addr`.
- `done`  in  1: high when the sequencer has no further byte.
- `next`  out  1: one-cycle pulse; the current byte has been consumed.
- `dout`  out  1: WS2812 serial data line.
- `busy`  out  1: high from the cycle after `trigger` is accepted until the latch period ends.

## Operation

- Reset state: IDLE. `dout`=0, `next`=0, `busy`=0. Bit counter, cycle counter and shift register are cleared.
- States:
  - IDLE: `trigger`=1 → WAIT, `busy`←1.
  - WAIT: lasts `RD_LAT` cycles, then the load point.
  - Load point, first byte:
    - `done`=1 → LATCH. No `next` pulse and no `dout` high.
    - `done`=0 → shift register ← `data`, `next`←1 for one cycle, go to BIT with bit index 7.
  - BIT: cycle counter runs 0..`TBIT`-1.
    - `dout`=1 while counter < (`sr[7]` ? `T1H` : `T0H`), otherwise 0.
    - At counter=`TBIT`-1 with bit index >0: shift left, decrement the index, restart the counter.
    - At counter=`TBIT`-1 with bit index =0: this is the load point for the next byte. Apply the same `done`/`data` rule as the first byte. The next byte starts on the following cycle, with no gap.
  - LATCH: `dout`=0 for `TRESET` cycles, then IDLE with `busy`←0.
- `trigger` in WAIT, BIT or LATCH is ignored and is not queued.
- `data` and `done` are sampled only at load points. Between load points they are don't-care.
- Reset in any state takes effect at the next edge. `dout` goes low and nothing resumes afterwards; the partial frame is lost.

## Timing

- All outputs are registered.
- First byte:
  - `trigger` is sampled high at edge E0.
  - `busy` rises after E0.
  - The load point is edge E0+`RD_LAT`+1.
  - `next` and the first `dout` high both start in the cycle after the load point.
- Bit timing: every bit period is exactly `TBIT` cycles. Rising edges of `dout` are spaced `TBIT` apart across byte boundaries.
- `next` pulses are exactly 8×`TBIT` cycles apart within a frame. That gives the sequencer 8×`TBIT`−1 cycles to present the next `data`/`done`, which must be ≥ `RD_LAT`.
- Frame of N bytes (N≥1):
  - `busy` is high for `RD_LAT`+1+8N×`TBIT`+`TRESET` cycles.
  - N=0: `busy` is high for `RD_LAT`+1+`TRESET` cycles.
- After `busy` falls, a `trigger` in that same cycle is accepted.

## Test plan

All scenarios use default parameters.

- **Single byte.** `data`=0xA5; `done` rises 2 cycles after the first `next`.
  - Required: 8 high pulses of widths 34,17,34,17,17,34,17,34, rising 60 cycles apart.
  - Exactly one `next`.
  - Then 2880 low cycles, then `busy` falls.
- **Empty frame.** `done`=1 at `trigger`.
  - Required: `next` never pulses and `dout` stays 0.
  - `busy` is high for exactly 2883 cycles.
- **Three-byte frame.** Bytes 0xFF, 0x00, 0x81 served by a model of `send` with `length`=3.
  - Required: 24 bits with rising edges spaced exactly 60 cycles and no gap at byte boundaries.
  - Three `next` pulses, 480 cycles apart.
  - High times match the bit values.
- **Trigger while busy.** Pulse `trigger` during BIT and again during LATCH.
  - Required: no change to the `dout` waveform, `next` count or `busy` duration.
  - A `trigger` in the cycle `busy` falls starts a new frame.
- **Mid-byte reset.** Assert `reset` for 1 cycle at bit 3 of byte 2.
  - Required: at the next edge `dout`=0, `busy`=0, `next`=0.
  - Stays idle until a new `trigger`.
  - A fresh 1-byte frame then encodes correctly.
- **Boundary `done` timing.** Assert `done` exactly `RD_LAT` cycles after the last `next`.
  - Required: it is sampled at the following load point; LATCH starts immediately after bit 0 of the last byte.
